decode_inst_queue: RTL and testbench
====================================

Name: decode_inst_queue

Overview:
- Small instruction queue between fetch and the decode/immediate-generation stage.
- Buffers fetched {pc, inst} pairs with valid/ready handshakes on both sides.
- Pre-decodes the 4-bit immediate-format select from each instruction word, plus an illegal-opcode flag, so the immediate generator receives select and inst aligned in the same cycle.
- Supports a pipeline flush for branch redirect.

Parameters:
- DEPTH, 2, number of queue entries; must be a power of two and at least 2.
- XLEN, 32, width of pc and inst.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- flush  in  1  discard all queued entries; the push in the same cycle is dropped.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept an entry.
- in_pc  in  XLEN  pc of the presented instruction.
- in_inst  in  XLEN  raw instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head entry.
- out_pc  out  XLEN  head pc.
- out_inst  out  XLEN  head instruction word.
- out_imm_sel  out  4  immediate format of the head instruction.
- out_illegal  out  1  head opcode is not recognised.

Behaviour:
- Handshakes:
  - Push occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
- Storage:
  - Circular buffer with rd_ptr, wr_ptr (log2(DEPTH) bits, wrapping) and count (log2(DEPTH)+1 bits).
- in_ready:
  - Low while reset or flush is high.
  - Low when count == DEPTH, even if a pop occurs that cycle (no simultaneous push/pop at full).
  - High otherwise.
- Latency and ordering:
  - An entry pushed in cycle N is visible at the outputs in cycle N+1 (out_valid = count != 0).
  - Entries leave in push order.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Empty queue: out_valid = 0 and out_pc/out_inst/out_imm_sel/out_illegal are driven to 0. They are never X.
- Flush:
  - On a clock edge with flush high, pointers and count return to 0.
  - out_valid is forced 0 combinationally during the flush cycle, so no pop completes.
  - Any push in that cycle is lost.
- Reset:
  - Same clearing as flush, plus in_ready = 0 during reset.
  - After reset deasserts: in_ready = 1, out_valid = 0.
  - Reset mid-stream discards everything.
- Select encoding on out_imm_sel, decoded from head inst[6:0] (and inst[14] for SYSTEM):
  - 0 NONE: OP 0110011, FENCE 0001111, SYSTEM with inst[14]=0.
  - 1 I: 0010011, 0000011, 1100111.
  - 2 S: 0100011.
  - 3 SB: 1100011.
  - 4 U: 0110111, 0010111.
  - 5 UJ: 1101111.
  - 6 Z: SYSTEM 1110011 with inst[14]=1.
  - Any other opcode: out_imm_sel = 0 and out_illegal = 1.
- Decode is combinational on the head entry. It may alternatively be computed at push time and stored alongside the entry; outputs must be identical either way.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined:
  - When count == 0, in_valid = 1 and flush = 0, the input passes combinationally to the outputs in the same cycle: out_valid = 1, out_pc/out_inst = in_pc/in_inst, and decode is applied to in_inst.
  - If out_ready is also 1, the entry is consumed with zero latency and not written.
  - If out_ready is 0, the entry is written as a normal push.
  - in_ready is unaffected.
- Not defined: strict one-cycle minimum latency as described above; no combinational path from the in_* ports to the out_* ports.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, all out_* zero for 5 cycles.
- Push pc=0x100 inst=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_imm_sel=1, out_illegal=0; following cycle out_valid=0. With IQ_BYPASS_EN: out_valid=1 in the push cycle, no entry is stored, and out_valid=0 the next cycle.
- out_ready=0, push sw 0x00112623 then beq 0x00208463 -> count=2, in_ready=0, third push is not accepted. Then out_ready=1 -> pops in order with out_imm_sel=2 then 3. in_ready returns to 1 the cycle after the first pop.
- Stream jal 0x0080006F, lui 0x123450B7, csrrwi 0x3400D073 continuously with out_ready=1 for 6 cycles -> out_imm_sel sequence 5,4,6. Pointers wrap with no loss or duplication.
- Queue holding 2 entries, flush=1 with in_valid=1 -> out_valid=0 that cycle. Next cycle count=0, out_valid=0, the flushed-cycle push is absent. A subsequent push emerges normally.
- Push inst=0x0000007F -> out_illegal=1, out_imm_sel=0. Assert reset while 1 entry is held -> queue empties and in_ready=0 during reset.

Source files
------------

// File: rtl/decode_inst_queue.sv
// Fetch-to-decode instruction queue with immediate-format pre-decode.
// Optional IQ_BYPASS_EN: empty-queue combinational pass-through.
module decode_inst_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [3:0]      out_imm_sel,
  output logic            out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [XLEN-1:0] r_pc   [DEPTH];
  logic [XLEN-1:0] r_inst [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [AW:0]     r_count;

  logic            w_empty;
  logic            w_byp;
  logic            w_push;
  logic            w_wr;
  logic            w_pop;
  logic            w_vld;
  logic [XLEN-1:0] w_hd_pc;
  logic [XLEN-1:0] w_hd_inst;
  logic [4:0]      w_dec;

  // {illegal, sel} from {inst[14], inst[6:0]}
  function automatic logic [4:0] f_dec(input logic [7:0] k);
    logic [4:0] d;
    d = 5'd0;
    case (k[6:0])
      7'b0110011,
      7'b0001111: d = 5'd0;
      7'b1110011: d = k[7] ? 5'd6 : 5'd0;
      7'b0010011,
      7'b0000011,
      7'b1100111: d = 5'd1;
      7'b0100011: d = 5'd2;
      7'b1100011: d = 5'd3;
      7'b0110111,
      7'b0010111: d = 5'd4;
      7'b1101111: d = 5'd5;
      default:    d = 5'b1_0000;
    endcase
    return d;
  endfunction

  assign w_empty  = (r_count == '0);
  assign in_ready = !reset && !flush && (r_count != FULL);
  assign w_push   = in_valid && in_ready;

`ifdef IQ_BYPASS_EN
  assign w_byp = w_empty && in_valid && !flush && !reset;
`else
  assign w_byp = 1'b0;
`endif

  assign w_vld = !flush && !reset && (!w_empty || w_byp);
  assign w_pop = w_vld && out_ready && !w_empty;
  // A bypassed entry taken this cycle never enters storage
  assign w_wr  = w_push && !(w_byp && out_ready);

  assign w_hd_pc   = w_byp ? in_pc   : r_pc[r_rd];
  assign w_hd_inst = w_byp ? in_inst : r_inst[r_rd];
  assign w_dec     = f_dec({w_hd_inst[14], w_hd_inst[6:0]});

  assign out_valid   = w_vld;
  assign out_pc      = w_vld ? w_hd_pc   : '0;
  assign out_inst    = w_vld ? w_hd_inst : '0;
  assign out_imm_sel = w_vld ? w_dec[3:0] : 4'd0;
  assign out_illegal = w_vld && w_dec[4];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !reset && !flush) begin
      r_pc[r_wr]   <= in_pc;
      r_inst[r_wr] <= in_inst;
    end
  end

endmodule

// File: tb/tb_decode_inst_queue.sv
// Directed bench for decode_inst_queue.
// Checks handshakes, ordering, pre-decode, flush and reset.
module tb_decode_inst_queue;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic [3:0]  out_imm_sel;
  logic        out_illegal;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]  sel_q[$];
  logic [31:0] pc_q[$];

  always #5 clk = ~clk;

  decode_inst_queue #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .out_imm_sel(out_imm_sel), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Next cycle: advance past the edge, settle inputs before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] inst);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    #3 chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("idle_ready", {31'b0, in_ready}, 32'd1);
      chk("idle_valid", {31'b0, out_valid}, 32'd0);
      chk("idle_pc", out_pc, 32'h0);
      chk("idle_inst", out_inst, 32'h0);
      chk("idle_sel", {28'b0, out_imm_sel}, 32'd0);
      chk("idle_ill", {31'b0, out_illegal}, 32'd0);
      tick();
    end

    // Single addi
    out_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h00500093);
`ifdef IQ_BYPASS_EN
    #3;
    chk("byp_valid", {31'b0, out_valid}, 32'd1);
    chk("byp_pc", out_pc, 32'h100);
    chk("byp_sel", {28'b0, out_imm_sel}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #3 chk("byp_after", {31'b0, out_valid}, 32'd0);
    tick();
`else
    #3 chk("lat_push_cyc", {31'b0, out_valid}, 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk("addi_valid", {31'b0, out_valid}, 32'd1);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_inst", out_inst, 32'h00500093);
    chk("addi_sel", {28'b0, out_imm_sel}, 32'd1);
    chk("addi_ill", {31'b0, out_illegal}, 32'd0);
    tick();
    #3 chk("addi_gone", {31'b0, out_valid}, 32'd0);
    tick();
`endif

    // Fill to full, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h00112623);
    tick();
    drive(1'b1, 32'h204, 32'h00208463);
    tick();
    drive(1'b1, 32'h208, 32'h00000013);
    #3;
    chk("full_ready", {31'b0, in_ready}, 32'd0);
    chk("full_head_pc", out_pc, 32'h200);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    #3;
    chk("pop1_ready", {31'b0, in_ready}, 32'd0);
    chk("pop1_pc", out_pc, 32'h200);
    chk("pop1_sel", {28'b0, out_imm_sel}, 32'd2);
    tick();
    #3;
    chk("pop2_ready", {31'b0, in_ready}, 32'd1);
    chk("pop2_pc", out_pc, 32'h204);
    chk("pop2_sel", {28'b0, out_imm_sel}, 32'd3);
    tick();
    #3 chk("no_third", {31'b0, out_valid}, 32'd0);
    tick();

    // Continuous stream with wrap
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1'b1, 32'h300, 32'h0080006F);
        1: drive(1'b1, 32'h304, 32'h123450B7);
        2: drive(1'b1, 32'h308, 32'h3400D073);
        default: drive(1'b0, 32'h0, 32'h0);
      endcase
      #3;
      if (out_valid) begin
        sel_q.push_back(out_imm_sel);
        pc_q.push_back(out_pc);
      end
      tick();
    end
    chk("strm_cnt", sel_q.size(), 32'd3);
    if (sel_q.size() == 3) begin
      chk("strm_sel0", {28'b0, sel_q[0]}, 32'd5);
      chk("strm_sel1", {28'b0, sel_q[1]}, 32'd4);
      chk("strm_sel2", {28'b0, sel_q[2]}, 32'd6);
      chk("strm_pc0", pc_q[0], 32'h300);
      chk("strm_pc2", pc_q[2], 32'h308);
    end

    // Flush with two held entries and a push
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h0000000F);
    tick();
    drive(1'b1, 32'h404, 32'h0000000F);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h408, 32'h00000013);
    out_ready = 1'b1;
    #3;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk("fl_empty", {31'b0, out_valid}, 32'd0);
    chk("fl_pc", out_pc, 32'h0);
    out_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h00000013);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk("post_fl_valid", {31'b0, out_valid}, 32'd1);
    chk("post_fl_pc", out_pc, 32'h500);
    out_ready = 1'b1;
    tick();
    #3 chk("post_fl_gone", {31'b0, out_valid}, 32'd0);
    tick();

    // Illegal opcode, then reset while holding it
    out_ready = 1'b0;
    drive(1'b1, 32'h600, 32'h0000007F);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk("ill_valid", {31'b0, out_valid}, 32'd1);
    chk("ill_flag", {31'b0, out_illegal}, 32'd1);
    chk("ill_sel", {28'b0, out_imm_sel}, 32'd0);
    reset = 1'b1;
    #1 chk("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #3;
    chk("after_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("after_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("after_rst_ill", {31'b0, out_illegal}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
